// File: rtl/bmc_pkg.sv
// Shared constants and types for the soft-decision branch-metric pipeline.
package bmc_pkg;

  localparam int SYM_CNT_W  = 16;
  localparam int DIST_W_MAX = 8;

  // Per-sample distance; wide enough for any soft-sample width up to DIST_W_MAX.
  typedef logic [DIST_W_MAX-1:0] dist_t;

  function automatic int bmc_metric_w(input int n_out, input int sw);
    return $clog2(n_out * ((2 ** sw) - 1) + 1);
  endfunction

endpackage

// File: rtl/bmc_argmin.sv
// Combinational minimum search over packed metrics; the lowest index wins ties.
module bmc_argmin #(
  parameter int NCW = 4,
  parameter int MW  = 4,
  parameter int IW  = 2
) (
  input  logic [NCW*MW-1:0] metrics,
  output logic [IW-1:0]     idx
);

  logic [MW-1:0] best;

  always_comb begin
    best = metrics[0 +: MW];
    idx  = '0;
    // Strict less-than keeps the earlier index on equal metrics.
    for (int c = 1; c < NCW; c++) begin
      if (metrics[c*MW +: MW] < best) begin
        best = metrics[c*MW +: MW];
        idx  = IW'(c);
      end
    end
  end

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage soft-decision branch-metric unit for a rate 1/N_OUT code.
// Define BMC_ERASURE_EN to add the per-sample in_erase mask.
module bmc_soft_pipe
  import bmc_pkg::*;
#(
  parameter  int N_OUT = 2,
  parameter  int SW    = 3,
  localparam int MW    = bmc_metric_w(N_OUT, SW),
  localparam int NCW   = 2 ** N_OUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_OUT*SW-1:0]  rx_samples,
`ifdef BMC_ERASURE_EN
  input  logic [N_OUT-1:0]     in_erase,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCW*MW-1:0]    bm,
  output logic [N_OUT-1:0]     min_idx,
  output logic [SYM_CNT_W-1:0] sym_cnt
);

  localparam logic [SW-1:0] SMAX = '1;

  // Handshake: a word moves on any edge where valid and ready are both high;
  // the whole pipe advances together, so in_ready is just "S2 can be refilled".
  logic advance;
  logic accept;

  logic                 s1_valid_d, s1_valid_q;
  dist_t                dist_d [NCW][N_OUT];
  dist_t                dist_q [NCW][N_OUT];
  logic                 out_valid_d, out_valid_q;
  logic [NCW*MW-1:0]    bm_d, bm_q;
  logic [N_OUT-1:0]     min_idx_d, min_idx_q;
  logic [SYM_CNT_W-1:0] sym_cnt_d, sym_cnt_q;

  logic [NCW*MW-1:0]    sums;
  logic [N_OUT-1:0]     min_idx_c;

  assign advance = !out_valid_q || out_ready;
  assign accept  = in_valid && advance;

  // Stage 1: distance of every sample against the expected bit of every codeword.
  always_comb begin
    s1_valid_d = s1_valid_q;
    dist_d     = dist_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        for (int c = 0; c < NCW; c++) begin
          for (int i = 0; i < N_OUT; i++) begin
            if (((c >> i) & 1) != 0) dist_d[c][i] = dist_t'(SMAX - rx_samples[i*SW +: SW]);
            else                     dist_d[c][i] = dist_t'(rx_samples[i*SW +: SW]);
`ifdef BMC_ERASURE_EN
            if (in_erase[i]) dist_d[c][i] = '0;
`endif
          end
        end
      end
    end
  end

  always_comb begin
    sums = '0;
    for (int c = 0; c < NCW; c++) begin
      for (int i = 0; i < N_OUT; i++) begin
        sums[c*MW +: MW] = sums[c*MW +: MW] + MW'(dist_q[c][i]);
      end
    end
  end

  bmc_argmin #(.NCW(NCW), .MW(MW), .IW(N_OUT)) u_argmin (
    .metrics (sums),
    .idx     (min_idx_c)
  );

  // Stage 2: metrics only reload on a real symbol so they hold while idle.
  always_comb begin
    out_valid_d = out_valid_q;
    bm_d        = bm_q;
    min_idx_d   = min_idx_q;
    sym_cnt_d   = sym_cnt_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        bm_d      = sums;
        min_idx_d = min_idx_c;
      end
    end
    if (accept) sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bm_q        <= '0;
      min_idx_q   <= '0;
      sym_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      bm_q        <= bm_d;
      min_idx_q   <= min_idx_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    dist_q <= dist_d;
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign bm        = bm_q;
  assign min_idx   = min_idx_q;
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: hand-derived vector table, back-pressure, reset and
// wrap sequences, plus random traffic scored against a behavioural model.
module tb_bmc_soft_pipe;

  localparam int N_OUT = 2;
  localparam int SW    = 3;
  localparam int MW    = 4;
  localparam int NCW   = 4;
  localparam int BM_W  = NCW * MW;
  localparam int OUT_W = BM_W + N_OUT;
  localparam int SMAX  = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        rx_samples;
  logic [1:0]        in_erase;
  logic              out_valid;
  logic              out_ready;
  logic [BM_W-1:0]   bm;
  logic [1:0]        min_idx;
  logic [15:0]       sym_cnt;

  logic              h_in_valid;
  logic              h_in_ready;
  logic [1:0]        h_rx;
  logic [1:0]        h_erase;
  logic              h_out_valid;
  logic              h_out_ready;
  logic [7:0]        h_bm;
  logic [1:0]        h_min;
  logic [15:0]       h_cnt;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic             hold_pending = 1'b0;
  logic [OUT_W-1:0] held;

  typedef struct {
    string      name;
    logic [5:0] rx;
    logic [1:0] er;
    logic [15:0] bm;
    logic [1:0] idx;
  } vec_t;
  vec_t vec_q[$];

  always #5 clk = ~clk;

  bmc_soft_pipe #(.N_OUT(2), .SW(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rx_samples (rx_samples),
`ifdef BMC_ERASURE_EN
    .in_erase   (in_erase),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bm         (bm),
    .min_idx    (min_idx),
    .sym_cnt    (sym_cnt)
  );

  bmc_soft_pipe #(.N_OUT(2), .SW(1)) u_dut_hard (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (h_in_valid),
    .in_ready   (h_in_ready),
    .rx_samples (h_rx),
`ifdef BMC_ERASURE_EN
    .in_erase   (h_erase),
`endif
    .out_valid  (h_out_valid),
    .out_ready  (h_out_ready),
    .bm         (h_bm),
    .min_idx    (h_min),
    .sym_cnt    (h_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each metric is the plain sum of per-sample distances to the codeword.
  function automatic logic [OUT_W-1:0] ref_model(input logic [5:0] rx, input logic [1:0] er);
    int m [NCW];
    int best;
    logic [BM_W-1:0] lanes;
    best  = 0;
    lanes = '0;
    for (int c = 0; c < NCW; c++) begin
      m[c] = 0;
      for (int i = 0; i < N_OUT; i++) begin
        int s;
        int b;
        s = int'(rx[i*SW +: SW]);
        b = (c >> i) & 1;
        if (!er[i]) m[c] += (b == 1) ? (SMAX - s) : s;
      end
      if (m[c] < m[best]) best = c;
      lanes[c*MW +: MW] = MW'(m[c]);
    end
    return {lanes, 2'(best)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_cnt    = 0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {14'd0, bm, min_idx}, {14'd0, held});
      end
      hold_pending = out_valid && !out_ready;
      held         = {bm, min_idx};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_output", 32'd1, 32'd0);
        end else begin
          logic [OUT_W-1:0] e;
          e = exp_q.pop_front();
          check("sb_output", {14'd0, bm, min_idx}, {14'd0, e});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(rx_samples, in_erase));
        model_cnt++;
      end
    end
  end

  task automatic send(input logic [5:0] rx, input logic [1:0] er);
    logic done;
    done       = 1'b0;
    in_valid   = 1'b1;
    rx_samples = rx;
    in_erase   = er;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic add_vec(input string n, input int s0, input int s1, input logic [1:0] er,
                         input int c0, input int c1, input int c2, input int c3, input int idx);
    vec_t v;
    v.name = n;
    v.rx   = {3'(s1), 3'(s0)};
    v.er   = er;
    v.bm   = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    v.idx  = 2'(idx);
    vec_q.push_back(v);
  endtask

  // Expects to start just after a rising edge with out_ready high.
  task automatic apply_vec(input vec_t v);
    in_valid   = 1'b1;
    rx_samples = v.rx;
    in_erase   = v.er;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({v.name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({v.name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({v.name, "_bm"}, {16'd0, bm}, {16'd0, v.bm});
    check({v.name, "_min"}, {30'd0, min_idx}, {30'd0, v.idx});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string n);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check(n, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; rx_samples = '0; in_erase = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_rx = '0; h_erase = '0; h_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    check("rst_bm", {16'd0, bm}, 32'd0);
    check("rst_min", {30'd0, min_idx}, 32'd0);

    // Hard-decision instance: samples {1,0} give metrics {1,0,2,1}.
    @(posedge clk); #1;
    h_rx = 2'b01; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hard_valid", {31'd0, h_out_valid}, 32'd1);
    check("hard_bm", {24'd0, h_bm}, {24'd0, 2'd1, 2'd2, 2'd0, 2'd1});
    check("hard_min", {30'd0, h_min}, 32'd1);
    check("hard_cnt", {16'd0, h_cnt}, 32'd1);
    @(posedge clk); #1;

    add_vec("zeros",   0, 0, 2'b00,  0,  7,  7, 14, 0);
    add_vec("s3_4",    3, 4, 2'b00,  7,  8,  6,  7, 2);
    add_vec("sevens",  7, 7, 2'b00, 14,  7,  7,  0, 3);
    add_vec("s7_0",    7, 0, 2'b00,  7,  0, 14,  7, 1);
    add_vec("s2_5",    2, 5, 2'b00,  7, 10,  4,  7, 2);
`ifdef BMC_ERASURE_EN
    add_vec("erase_all", 3, 4, 2'b11, 0, 0, 0, 0, 0);
    add_vec("erase_s0",  3, 4, 2'b01, 4, 4, 3, 3, 2);
`endif
    for (int v = 0; v < vec_q.size(); v++) apply_vec(vec_q[v]);
    drain("table_drain");

    // Back-pressure: four symbols against a stalled sink.
    out_ready = 1'b0;
    fork
      begin
        send(6'o12, 2'b00);
        send(6'o34, 2'b00);
        send(6'o56, 2'b00);
        send(6'o70, 2'b00);
      end
      begin
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with both stages holding data and an input offered.
    out_ready = 1'b0;
    send(6'o11, 2'b00);
    send(6'o22, 2'b00);
    rst = 1'b1; in_valid = 1'b1; rx_samples = 6'o33;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst2_discard", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 400; k++) begin
      in_valid   = 1'($urandom_range(0, 1));
      rx_samples = 6'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
`ifdef BMC_ERASURE_EN
      in_erase   = 2'($urandom_range(0, 3));
`endif
      @(posedge clk); #1;
    end
    in_erase = '0;
    drain("rand_drain");
    @(negedge clk);
    check("rand_sym_cnt", {16'd0, sym_cnt}, {16'd0, 16'(model_cnt)});
    @(posedge clk); #1;

    // Counter wrap: 65535 accepts reach 0xFFFF, the next one wraps to 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 65535; k++) begin
      rx_samples = 6'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wrap_ffff", {16'd0, sym_cnt}, 32'h0000_ffff);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_zero", {16'd0, sym_cnt}, 32'd0);
    drain("wrap_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmc_soft_pipe.md
BMC_SOFT_PIPE -- requirements
Module: bmc_soft_pipe

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- N_OUT, 2, code outputs per symbol; rate 1/N_OUT.
- SW, 3, soft-sample width; SW=1 means hard decision.
- MW, $clog2(N_OUT*(2**SW-1)+1), metric width; derived, not overridable.
- NCW, 2**N_OUT, number of candidate codewords; derived.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  rx_samples is valid.
- in_ready  out  1  block accepts this cycle.
- rx_samples  in  N_OUT*SW  sample i at [i*SW +: SW]; 0 = strongest '0', 2**SW-1 = strongest '1'.
- in_erase  in  N_OUT  per-sample erasure mask; present only with BMC_ERASURE_EN.
- out_valid  out  1  metrics valid.
- out_ready  in  1  downstream accepts.
- bm  out  NCW*MW  metric of codeword c at [c*MW +: MW].
- min_idx  out  N_OUT  index of the smallest metric.
- sym_cnt  out  16  count of accepted symbols.

Function
REQ-003 Codeword c SHALL expect bit i equal to bit i of c.
REQ-004 Per-sample distance SHALL be the sample value when the expected bit is 0, and (2**SW-1) minus the sample value when the expected bit is 1.
REQ-005 bm[c] SHALL be the unsigned sum of the N_OUT distances, held at MW bits, with no overflow possible.
REQ-006 Transfer SHALL occur on cycles with in_valid&in_ready; output handoff SHALL occur on cycles with out_valid&out_ready.
REQ-007 Pipeline SHALL have 2 stages:
- S1 registers the per-sample distances for every codeword.
- S2 registers the sums, min_idx and valid.
REQ-008 advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-009 When advance is high:
- S1 captures the input and S1.valid <= in_valid.
- S2 captures S1 and out_valid <= S1.valid.
REQ-010 When advance is low, every register SHALL hold.
REQ-011 Latency: a symbol accepted at edge k SHALL present out_valid=1 after edge k+2 when out_ready stays high.
REQ-012 While out_valid=1 and out_ready=0, bm, min_idx and out_valid SHALL remain stable.
REQ-013 Symbols SHALL never be dropped or duplicated, and output order SHALL equal input order.
REQ-014 Throughput SHALL be one symbol per cycle under continuous in_valid and out_ready.
REQ-015 min_idx SHALL be the index of the minimum bm; on a tie, the lowest index wins.
REQ-016 sym_cnt SHALL increment by 1 per accepted input and wrap from 0xFFFF to 0.
REQ-017 bm and min_idx SHALL be unspecified-stable (hold last value) while out_valid=0; checkers SHALL ignore them then.

Reset
REQ-018 With rst=1 at an edge, the block SHALL clear: S1.valid, out_valid, every bm lane, min_idx and sym_cnt all to 0.
REQ-019 Reset SHALL override a simultaneous transfer; an input offered during reset is not counted and is discarded.
REQ-020 in_ready SHALL read 1 in the first cycle after reset.

Configuration
REQ-021 Macro BMC_ERASURE_EN SHALL control erasure support.
- Defined: in_erase exists, and an erased sample contributes distance 0 to every codeword.
- Undefined: in_erase is absent, and all samples contribute.
- Timing, handshake and all other behaviour SHALL be identical in both builds.

Structure
REQ-022 Package bmc_pkg SHALL hold:
- the metric-width function;
- the sym_cnt width constant (16);
- a typedef for the per-sample distance.
REQ-023 Sub-module bmc_argmin SHALL implement the combinational NCW-way minimum search with lowest-index tie-break, instantiated before S2.

Verification (N_OUT=2 unless stated)
REQ-024 SW=3, samples {0,0}:
- bm = {0,7,7,14}, min_idx=0.
- out_valid 2 cycles after accept.
REQ-025 SW=1, rx_samples=2'b01:
- bm = {1,0,2,1}, min_idx=1.
REQ-026 Back-pressure:
- 4 symbols back-to-back with out_ready=0 for 3 cycles.
- in_ready drops once the pipe is full; outputs hold stable.
- All 4 emerge in order, none lost or duplicated.
REQ-027 BMC_ERASURE_EN defined, SW=3, samples {3,4}:
- in_erase=2'b11 -> bm all 0, min_idx=0 (tie rule).
- in_erase=2'b00 -> bm = {7,8,6,7}, min_idx=2.
REQ-028 rst asserted with both stages valid -> next cycle out_valid=0, sym_cnt=0, in_ready=1.
REQ-029 sym_cnt preloaded to 0xFFFF via 65535 accepts -> one more accept gives sym_cnt=0.
